// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU op codes, operand selects, immediate
// formats, opcode constants and the decoded-instruction bundle.
package riscv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } oper1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2
    } oper2_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] imm;
        alu_op_e     alu_op;
        oper1_sel_e  oper1_sel;
        oper2_sel_e  oper2_sel;
        logic [2:0]  funct3;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } decoded_t;

    // Shared funct3 map for OP and OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_e alu_from_funct3(logic [2:0] funct3, logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended 32-bit immediate for the
// selected RV32I format.
//   instr_i     instruction bits [31:7] (opcode bits carry no immediate)
//   imm_type_i  immediate format
//   imm_o       sign-extended immediate
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_type_e   imm_type_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_type_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a single registered output slot.
//   clk_i, rst_ni              clock, async active-low reset
//   flush_i                    drop held and incoming instruction
//   in_valid_i/in_ready_o      fetch handshake carrying instr_i, pc_i
//   out_valid_o/out_ready_i    execute handshake for the decoded bundle
//   out_pc_o .. illegal_o      registered decoded bundle
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic [31:0] imm_o,
    output logic [4:0]  alu_op_o,
    output logic [1:0]  oper1_sel_o,
    output logic [1:0]  oper2_sel_o,
    output logic [2:0]  funct3_o,
    output logic        is_branch_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        illegal_o
);

    typedef enum logic {StEmpty, StFull} slot_e;

    slot_e      state_q, state_d;
    decoded_t   dec, bundle_d, bundle_q;
    imm_type_e  imm_type;
    logic [31:0] imm;
    logic       capture;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       writes_rd;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    imm_gen u_imm_gen (
        .instr_i    (instr_i[31:7]),
        .imm_type_i (imm_type),
        .imm_o      (imm)
    );

    always_comb begin
        dec           = '0;
        dec.pc        = pc_i;
        dec.rs1_addr  = instr_i[19:15];
        dec.rs2_addr  = instr_i[24:20];
        dec.rd_addr   = instr_i[11:7];
        dec.funct3    = funct3;
        dec.alu_op    = ALU_ADD;
        dec.oper1_sel = OP1_RS1;
        dec.oper2_sel = OP2_RS2;
        imm_type      = IMM_I;
        writes_rd     = 1'b0;

        case (opcode)
            OPC_LUI: begin
                dec.oper1_sel = OP1_ZERO;
                dec.oper2_sel = OP2_IMM;
                imm_type      = IMM_U;
                writes_rd     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.oper1_sel = OP1_PC;
                dec.oper2_sel = OP2_IMM;
                imm_type      = IMM_U;
                writes_rd     = 1'b1;
            end
            OPC_JAL: begin
                dec.oper1_sel = OP1_PC;
                dec.oper2_sel = OP2_FOUR;
                imm_type      = IMM_J;
                dec.is_jal    = 1'b1;
                writes_rd     = 1'b1;
            end
            OPC_JALR: begin
                dec.oper1_sel = OP1_PC;
                dec.oper2_sel = OP2_FOUR;
                dec.is_jalr   = 1'b1;
                writes_rd     = 1'b1;
                dec.illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.alu_op    = ALU_SUB;
                imm_type      = IMM_B;
                dec.is_branch = 1'b1;
                dec.illegal   = (funct3 inside {3'b010, 3'b011});
            end
            OPC_LOAD: begin
                dec.oper2_sel = OP2_IMM;
                dec.is_load   = 1'b1;
                writes_rd     = 1'b1;
                dec.illegal   = (funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_STORE: begin
                dec.oper2_sel = OP2_IMM;
                imm_type      = IMM_S;
                dec.is_store  = 1'b1;
                dec.illegal   = (funct3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                dec.oper2_sel = OP2_IMM;
                writes_rd     = 1'b1;
                if (funct3 == 3'b001) begin
                    dec.alu_op  = ALU_SLL;
                    dec.illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.alu_op  = alu_from_funct3(funct3, instr_i[30]);
                    dec.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else begin
                    // Upper bits are immediate here, so ADDI never becomes SUB.
                    dec.alu_op  = alu_from_funct3(funct3, 1'b0);
                end
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_op = alu_from_funct3(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec.alu_op = alu_from_funct3(funct3, 1'b1);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE is a NOP in this in-order core.
            end
            default: dec.illegal = 1'b1;
        endcase

        // Illegal encodings still flow downstream but must be side-effect free.
        if (dec.illegal) begin
            dec.alu_op    = ALU_ADD;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
        end
        dec.rd_we = writes_rd && (dec.rd_addr != 5'd0) && !dec.illegal;
    end

    always_comb begin
        bundle_d     = dec;
        bundle_d.imm = imm;
    end

    assign out_valid_o = (state_q == StFull);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign capture     = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else if (capture) begin
            state_d = StFull;
        end else if (out_ready_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StEmpty;
            bundle_q        <= '0;
            bundle_q.pc     <= RESET_PC;
            bundle_q.alu_op <= ALU_ADD;
        end else begin
            state_q <= state_d;
            if (capture) begin
                bundle_q <= bundle_d;
            end
        end
    end

    assign out_pc_o    = bundle_q.pc;
    assign rs1_addr_o  = bundle_q.rs1_addr;
    assign rs2_addr_o  = bundle_q.rs2_addr;
    assign rd_addr_o   = bundle_q.rd_addr;
    assign rd_we_o     = bundle_q.rd_we;
    assign imm_o       = bundle_q.imm;
    assign alu_op_o    = bundle_q.alu_op;
    assign oper1_sel_o = bundle_q.oper1_sel;
    assign oper2_sel_o = bundle_q.oper2_sel;
    assign funct3_o    = bundle_q.funct3;
    assign is_branch_o = bundle_q.is_branch;
    assign is_jal_o    = bundle_q.is_jal;
    assign is_jalr_o   = bundle_q.is_jalr;
    assign is_load_o   = bundle_q.is_load;
    assign is_store_o  = bundle_q.is_store;
    assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued when an
// instruction is accepted and compared while the slot presents them.
module tb_decode_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [1:0]  oper1_sel, oper2_sel;
    logic [2:0]  funct3;
    logic        is_branch, is_jal, is_jalr, is_load, is_store, illegal;

    decode_stage #(.RESET_PC(RPC)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .pc_i        (pc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pc_o    (out_pc),
        .rs1_addr_o  (rs1_addr),
        .rs2_addr_o  (rs2_addr),
        .rd_addr_o   (rd_addr),
        .rd_we_o     (rd_we),
        .imm_o       (imm),
        .alu_op_o    (alu_op),
        .oper1_sel_o (oper1_sel),
        .oper2_sel_o (oper2_sel),
        .funct3_o    (funct3),
        .is_branch_o (is_branch),
        .is_jal_o    (is_jal),
        .is_jalr_o   (is_jalr),
        .is_load_o   (is_load),
        .is_store_o  (is_store),
        .illegal_o   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [1:0]  op1, op2;
        logic [2:0]  f3;
        logic [4:0]  flags;   // {branch, jal, jalr, load, store}
        logic        ill;
        logic        chk_ops;
        logic        chk_imm;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;

    function automatic exp_t mk(logic [31:0] p, logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                                logic w, logic [31:0] im, logic [4:0] a, logic [1:0] o1,
                                logic [1:0] o2, logic [2:0] f, logic [4:0] fl, logic il,
                                logic co, logic ci);
        exp_t e;
        e.pc = p; e.rs1 = r1; e.rs2 = r2; e.rd = d; e.we = w; e.imm = im; e.alu = a;
        e.op1 = o1; e.op2 = o2; e.f3 = f; e.flags = fl; e.ill = il;
        e.chk_ops = co; e.chk_imm = ci;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_bundle(input exp_t e);
        chk("pc", out_pc, e.pc);
        chk("rs1", {27'd0, rs1_addr}, {27'd0, e.rs1});
        chk("rs2", {27'd0, rs2_addr}, {27'd0, e.rs2});
        chk("rd", {27'd0, rd_addr}, {27'd0, e.rd});
        chk("rd_we", {31'd0, rd_we}, {31'd0, e.we});
        chk("alu_op", {27'd0, alu_op}, {27'd0, e.alu});
        chk("funct3", {29'd0, funct3}, {29'd0, e.f3});
        chk("flags", {27'd0, is_branch, is_jal, is_jalr, is_load, is_store},
            {27'd0, e.flags});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (e.chk_ops) begin
            chk("oper1", {30'd0, oper1_sel}, {30'd0, e.op1});
            chk("oper2", {30'd0, oper2_sel}, {30'd0, e.op2});
        end
        if (e.chk_imm) chk("imm", imm, e.imm);
    endtask

    // One clock cycle: compare at the falling edge, then update the scoreboard
    // with what the upcoming rising edge transfers and captures.
    task automatic tick();
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = (sb.size() == 0) || out_ready;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (sb.size() != 0) begin
            cmp_bundle(sb[0]);
            if (out_ready) sb.delete(0);
        end
        if (flush) sb.delete();
        else if (in_valid && exp_rdy) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p, input exp_t e);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        pend     = e;
        tick();
    endtask

    initial begin
        exp_t ea, e1, e2, e3;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, RPC);
        chk("rst_alu", {27'd0, alu_op}, {27'd0, ALU_ADD});
        chk("rst_imm", imm, 32'd0);
        chk("rst_flags", {26'd0, rd_we, is_branch, is_jal, is_jalr, is_load, is_store},
            32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Streamed decode with execute always ready.
        out_ready = 1'b1;
        send(32'hFFB10093, 32'h1000, mk(32'h1000, 2, 27, 1, 1, 32'hFFFFFFFB, ALU_ADD,
             OP1_RS1, OP2_IMM, 0, 5'b00000, 0, 1, 1));
        send(32'h405201B3, 32'h1004, mk(32'h1004, 4, 5, 3, 1, 0, ALU_SUB,
             OP1_RS1, OP2_RS2, 0, 5'b00000, 0, 1, 0));
        send(32'h405241B3, 32'h1008, mk(32'h1008, 4, 5, 3, 0, 0, ALU_ADD,
             0, 0, 4, 5'b00000, 1, 0, 0));
        send(32'h123453B7, 32'h100C, mk(32'h100C, 8, 3, 7, 1, 32'h12345000, ALU_ADD,
             OP1_ZERO, OP2_IMM, 5, 5'b00000, 0, 1, 1));
        send(32'h008000EF, 32'h1010, mk(32'h1010, 0, 8, 1, 1, 32'h8, ALU_ADD,
             OP1_PC, OP2_FOUR, 0, 5'b01000, 0, 1, 1));
        send(32'h00208863, 32'h1014, mk(32'h1014, 1, 2, 16, 0, 32'h10, ALU_SUB,
             OP1_RS1, OP2_RS2, 0, 5'b10000, 0, 1, 1));
        send(32'hFE532E23, 32'h1018, mk(32'h1018, 6, 5, 28, 0, 32'hFFFFFFFC, ALU_ADD,
             OP1_RS1, OP2_IMM, 2, 5'b00001, 0, 1, 1));
        send(32'h4034D413, 32'h101C, mk(32'h101C, 9, 3, 8, 1, 32'h403, ALU_SRA,
             OP1_RS1, OP2_IMM, 5, 5'b00000, 0, 1, 1));
        send(32'h000290E7, 32'h1020, mk(32'h1020, 5, 0, 1, 0, 0, ALU_ADD,
             0, 0, 1, 5'b00000, 1, 0, 0));
        send(32'h00000013, 32'h1024, mk(32'h1024, 0, 0, 0, 0, 32'h0, ALU_ADD,
             OP1_RS1, OP2_IMM, 0, 5'b00000, 0, 1, 1));
        in_valid = 1'b0;
        tick();

        // Back-pressure: first instruction held, second stalled at the input.
        e1 = mk(32'h2000, 0, 1, 1, 1, 32'h1, ALU_ADD, OP1_RS1, OP2_IMM, 0, 0, 0, 1, 1);
        e2 = mk(32'h2004, 0, 2, 2, 1, 32'h2, ALU_ADD, OP1_RS1, OP2_IMM, 0, 0, 0, 1, 1);
        e3 = mk(32'h2008, 0, 3, 3, 1, 32'h3, ALU_ADD, OP1_RS1, OP2_IMM, 0, 0, 0, 1, 1);
        out_ready = 1'b0;
        send(32'h00100093, 32'h2000, e1);
        instr = 32'h00200113; pc = 32'h2004; pend = e2;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        send(32'h00300193, 32'h2008, e3);
        in_valid = 1'b0;
        tick();

        // Flush with a full slot and a valid input in the same cycle.
        ea = mk(32'h3000, 0, 10, 1, 1, 32'hA, ALU_ADD, OP1_RS1, OP2_IMM, 0, 0, 0, 1, 1);
        out_ready = 1'b0;
        send(32'h00A00093, 32'h3000, ea);
        instr = 32'h00200113; pc = 32'h3004; pend = e2;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset while the slot is full.
        ea.pc = 32'h3100;
        out_ready = 1'b0;
        send(32'h00A00093, 32'h3100, ea);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("amid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("amid_pc", out_pc, RPC);
        chk("amid_rd_we", {31'd0, rd_we}, 32'd0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00000000, 32'h4000, mk(32'h4000, 0, 0, 0, 0, 0, ALU_ADD,
             0, 0, 0, 5'b00000, 1, 0, 0));
        in_valid = 1'b0;
        tick();
        tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode pipeline stage for the RV32I core; it is the upstream producer of the ALU's operation select and operand-source controls.
- Accepts a fetched instruction and PC over a valid/ready handshake, decodes opcode/funct3/funct7 into an ALU op code, operand selects, register indices and a sign-extended immediate.
- Presents the decoded bundle from a single registered pipeline slot to the execute stage.
- Supports back-pressure and flush.

Parameters:
RESET_PC, 32'h0000_0000, value driven on out_pc_o during reset

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  discard held and incoming instruction (branch/jump redirect)
in_valid_i  input  1  fetch presents instr_i/pc_i
in_ready_o  output  1  stage can accept this cycle
instr_i  input  32  raw instruction word
pc_i  input  32  instruction address
out_valid_o  output  1  decoded bundle valid
out_ready_i  input  1  execute accepts bundle
out_pc_o  output  32  registered PC
rs1_addr_o  output  5  source register 1 index
rs2_addr_o  output  5  source register 2 index
rd_addr_o  output  5  destination index
rd_we_o  output  1  register writeback enable
imm_o  output  32  sign-extended immediate
alu_op_o  output  5  ALU op code (package enum)
oper1_sel_o  output  2  OP1_RS1 / OP1_PC / OP1_ZERO
oper2_sel_o  output  2  OP2_RS2 / OP2_IMM / OP2_FOUR
funct3_o  output  3  passed to branch and LSU
is_branch_o, is_jal_o, is_jalr_o, is_load_o, is_store_o  output  1 each  class flags
illegal_o  output  1  unsupported or malformed encoding

Behaviour:
- Reset (async, rst_ni low):
  - out_valid_o = 0.
  - All bundle outputs = 0, except out_pc_o = RESET_PC and alu_op_o = ALU_ADD.
- Slot state: EMPTY (out_valid_o = 0) or FULL (out_valid_o = 1).
- in_ready_o = !out_valid_o || out_ready_i. This is combinational, and it does not depend on in_valid_i.
- Capture occurs on a rising edge when in_valid_i && in_ready_o && !flush_i. The decoded bundle is registered and out_valid_o = 1 on the next cycle, giving one-cycle latency.
- Transitions:
  - EMPTY→FULL on capture.
  - FULL→EMPTY when out_ready_i is high with no capture.
  - FULL→FULL when out_ready_i is high with a simultaneous capture, giving back-to-back throughput of 1 per cycle.
  - FULL with out_ready_i low: hold. Every bundle output is stable and in_ready_o = 0.
- flush_i has priority over everything: the next state is EMPTY, and a same-cycle input is dropped. Bundle contents need not clear.
- A bundle is transferred downstream only when out_valid_o && out_ready_i.
- Decode table, as oper1, oper2, alu_op, immediate type:
  - LUI 0110111: ZERO, IMM, ADD, U
  - AUIPC 0010111: PC, IMM, ADD, U
  - JAL 1101111: PC, FOUR, ADD, J; is_jal
  - JALR 1100111: PC, FOUR, ADD, I; is_jalr; funct3 must be 000 else illegal
  - BRANCH 1100011: RS1, RS2, SUB, B; is_branch; rd_we = 0; funct3 010/011 illegal
  - LOAD 0000011: RS1, IMM, ADD, I; is_load; funct3 011/110/111 illegal
  - STORE 0100011: RS1, IMM, ADD, S; is_store; rd_we = 0; funct3 ≥ 011 illegal
  - OP-IMM 0010011: RS1, IMM, I; funct3 maps 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL/SRA. SRA is selected by instr[30]. Shift forms require instr[31:25] = 0000000, or 0100000 for SRAI only, else illegal.
  - OP 0110011: RS1, RS2, same funct3 map. instr[31:25] must be 0000000, or 0100000 only for ADD→SUB and SRL→SRA, else illegal.
  - MISC-MEM 0001111 (FENCE): NOP, i.e. ADD, rd_we = 0.
  - Any other opcode, including SYSTEM: illegal.
- Immediates use instr[31] as the sign bit for all types. The U type has its low 12 bits zero. The B and J types have bit 0 zero.
- rd_we_o = 0 whenever rd = x0 or illegal_o = 1.
- Illegal instructions still flow: out_valid_o = 1, illegal_o = 1, alu_op = ADD, all class flags 0.
- rs1/rs2/rd fields are always extracted from fixed bit positions [19:15], [24:20] and [11:7], regardless of format.

Decomposition:
- Shared package riscv_pkg:
  - ALU op enum, 5-bit: ALU_ADD=0, ALU_SUB=1, ALU_SLL=2, ALU_SLT=3, ALU_SLTU=4, ALU_XOR=5, ALU_SRL=6, ALU_SRA=7, ALU_OR=8, ALU_AND=9.
  - oper1_sel_t and oper2_sel_t enums.
  - Opcode localparams.
  - Decoded-bundle struct.
- One combinational sub-module, imm_gen (instruction → 32-bit immediate by type). The decode logic and pipeline register stay in the top.

Test Plan:
- ADDI x1,x2,-5 (0xFFB10093), out_ready_i = 1 → next cycle out_valid_o = 1, rs1 = 2, rd = 1, imm = 0xFFFFFFFB, ALU_ADD, OP1_RS1, OP2_IMM, rd_we = 1.
- SUB x3,x4,x5 (0x405201B3) → ALU_SUB, rs1 = 4, rs2 = 5, OP2_RS2. The same bits with funct7 = 0100000 on XOR (0x405241B3) → illegal_o = 1, rd_we = 0.
- LUI x7,0x12345 (0x123453B7) → imm = 0x12345000, OP1_ZERO, ALU_ADD. JAL x1,+8 (0x008000EF) → is_jal, imm = 8, OP1_PC, OP2_FOUR.
- Back-pressure: three instructions streamed with out_ready_i held low for 3 cycles → in_ready_o = 0 and outputs frozen on the first instruction. After release, all three emerge in order with no loss or duplication.
- Flush: FULL slot plus a valid input while flush_i = 1 → next cycle out_valid_o = 0, and neither instruction is ever presented.
- Reset mid-stream: rst_ni low while FULL → out_valid_o = 0 and out_pc_o = RESET_PC immediately, without waiting for a clock edge. Instr 0x00000000 after reset → illegal_o = 1.
